// File: rtl/net_arb_pkg.sv
// Shared types and helpers for the TX port arbiter and its skid buffer.
// rr_pick performs the wrap-around first-set search starting at the round-robin pointer.
package net_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_PKT} arb_state_t;

  localparam int unsigned ARB_CNT_W   = 32;
  localparam int unsigned ARB_MAX_REQ = 8;
  localparam int unsigned ARB_IDX_W   = 3;

  // First set bit of req at or above ptr, wrapping at n; only indices below n are considered.
  function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                                   input logic [ARB_IDX_W-1:0]   ptr,
                                                   input int unsigned            n);
    logic [ARB_IDX_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[ARB_IDX_W-1:0]]) begin
        pick  = ARB_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/net_tx_rr_arbiter_if.sv
// AXI-stream bundle of the TX arbiter: NUM_REQ packed source streams in, one stream out to the MAC.
// master = the sources/MAC side, slave = the arbiter.
interface net_tx_rr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned KW = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            s_tvalid;
  logic [NUM_REQ-1:0]            s_tready;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ*KW-1:0]         s_tkeep;
  logic [NUM_REQ-1:0]            s_tlast;

  logic                          m_tvalid;
  logic                          m_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic [KW-1:0]                 m_tkeep;
  logic                          m_tlast;

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
  );

endinterface

// File: rtl/net_axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer: registered outputs, one cycle latency, full rate under
// continuous m_ready. Shared by TX and RX paths.
module net_axis_skid_buffer #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic          s_fire;
  logic          out_free;

  // Ready depends only on the second entry, so it never combinationally follows m_ready.
  assign s_ready  = ~skid_valid;
  assign s_fire   = s_valid & s_ready;
  assign out_free = ~m_valid | m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_data     <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= s_fire;
        if (s_fire) m_data <= s_data;
      end
    end else if (s_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/net_tx_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one 10G TX AXI-stream port among NUM_REQ sources.
// Define NET_TX_ARB_STATS_EN to build the per-requester forwarded-frame counters on pkt_cnt.
module net_tx_rr_arbiter
  import net_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                           clk156,
  input  logic                           aresetn,
  net_tx_rr_arbiter_if.slave             bus,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [NUM_REQ*ARB_CNT_W-1:0]   pkt_cnt
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned PW = DATA_WIDTH + KW + 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]         sel_keep;
  logic                  skid_valid_in;
  logic                  skid_ready;
  logic                  accept;
  logic [PW-1:0]         skid_out;

  // Source mux driven by the held grant.
  always_comb begin
    sel_valid = bus.s_tvalid[grant_q];
    sel_last  = bus.s_tlast[grant_q];
    sel_data  = bus.s_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_keep  = bus.s_tkeep[32'(grant_q)*KW +: KW];
  end

  assign skid_valid_in = (state_q == ARB_PKT) && sel_valid;
  assign accept        = skid_valid_in && skid_ready;

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Arbitrate only while idle; the grant holds until the granted source's tlast is accepted.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|bus.s_tvalid) begin
          grant_d = GW'(rr_pick(ARB_MAX_REQ'(bus.s_tvalid), ARB_IDX_W'(rr_ptr_q), NUM_REQ));
          state_d = ARB_PKT;
        end
      end
      ARB_PKT: begin
        if (accept && sel_last) begin
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.s_tready = '0;
    if (state_q == ARB_PKT) bus.s_tready[grant_q] = skid_ready;
  end

  net_axis_skid_buffer #(
    .DW (PW)
  ) u_skid (
    .clk     (clk156),
    .rst_n   (aresetn),
    .s_valid (skid_valid_in),
    .s_ready (skid_ready),
    .s_data  ({sel_last, sel_keep, sel_data}),
    .m_valid (bus.m_tvalid),
    .m_ready (bus.m_tready),
    .m_data  (skid_out)
  );

  assign bus.m_tlast = skid_out[PW-1];
  assign bus.m_tkeep = skid_out[DATA_WIDTH +: KW];
  assign bus.m_tdata = skid_out[DATA_WIDTH-1:0];

  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_PKT);

`ifdef NET_TX_ARB_STATS_EN
  logic [NUM_REQ*ARB_CNT_W-1:0] cnt_q;

  // Frame counters advance on each accepted tlast beat and wrap naturally.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (accept && sel_last) begin
      cnt_q[32'(grant_q)*ARB_CNT_W +: ARB_CNT_W] <=
        cnt_q[32'(grant_q)*ARB_CNT_W +: ARB_CNT_W] + ARB_CNT_W'(1);
    end
  end

  assign pkt_cnt = cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_net_tx_rr_arbiter.sv
// Bench for net_tx_rr_arbiter: frame-level source queues, a buffer/arbitration reference model
// checked every cycle, and directed scenarios pinned with literal expectations.
`timescale 1ns/1ps
module tb_net_tx_rr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] data;
    logic          last;
  } obs_t;

  logic clk156  = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk156 = ~clk156;

  logic [GW-1:0]   grant_id;
  logic            busy;
  logic [N*32-1:0] pkt_cnt;

  net_tx_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  net_tx_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk156   (clk156),
    .aresetn  (aresetn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  // Sources and model state
  beat_t       src_q[N][$];
  bit          gap[N];
  bit          gap_en;
  int          rdy_mode;
  bit          mrdy;
  int          owner;
  int          ptr;
  int          mgrant;
  beat_t       held[$];
  logic [31:0] mcnt[N];
  int          cyc;
  int          fid;
  bit          chk_en;

  int total;
  int bad;

  // Observation logs of the DUT, used for literal scenario checks
  int          dut_grants[$];
  obs_t        dut_beats[$];
  logic [31:0] cnt1_log[$];
  logic [31:0] cnt1_prev;
  logic        busy_prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N*32-1:0] exp_cnt();
    logic [N*32-1:0] e;
    e = '0;
`ifdef NET_TX_ARB_STATS_EN
    for (int r = 0; r < N; r++) e[r*32 +: 32] = mcnt[r];
`endif
    return e;
  endfunction

  task automatic apply_drives();
    for (int r = 0; r < N; r++) begin
      if (src_q[r].size() > 0 && !gap[r]) begin
        bus.s_tvalid[r]          = 1'b1;
        bus.s_tdata[r*DW +: DW]  = src_q[r][0].data;
        bus.s_tkeep[r*KW +: KW]  = src_q[r][0].keep;
        bus.s_tlast[r]           = src_q[r][0].last;
      end else begin
        bus.s_tvalid[r]          = 1'b0;
        bus.s_tdata[r*DW +: DW]  = '0;
        bus.s_tkeep[r*KW +: KW]  = '0;
        bus.s_tlast[r]           = 1'b0;
      end
    end
    bus.m_tready = mrdy;
  endtask

  task automatic add_frame(input int r, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(r), 8'(fid), 16'(i), 32'($urandom)};
      b.keep = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (i == len - 1);
      src_q[r].push_back(b);
    end
    fid++;
    apply_drives();
  endtask

  task automatic add_single(input int r, input logic [DW-1:0] d);
    beat_t b;
    b.data = d;
    b.keep = 8'hFF;
    b.last = 1'b1;
    src_q[r].push_back(b);
    apply_drives();
  endtask

  // One clock: advance the model from the pre-edge inputs, then drive the next cycle.
  task automatic step();
    logic [N-1:0] v;
    bit           sfire;
    bit           mfire;
    beat_t        b;
    @(posedge clk156);
    v     = bus.s_tvalid;
    mfire = (held.size() > 0) && mrdy;
    sfire = (owner >= 0) && v[owner] && (held.size() < 2);
    for (int r = 0; r < N; r++) gap[r] = 1'b0;
    if (mfire) void'(held.pop_front());
    if (sfire) begin
      b = src_q[owner].pop_front();
      held.push_back(b);
      gap[owner] = gap_en && ($urandom_range(3) == 0);
      if (b.last) begin
        mcnt[owner] = mcnt[owner] + 32'd1;
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end else if (owner < 0 && v != '0) begin
      owner  = pick(v, ptr);
      mgrant = owner;
    end
    #1;
    cyc++;
    case (rdy_mode)
      0:       mrdy = 1'b1;
      1:       mrdy = ($urandom_range(3) != 0);
      default: mrdy = !((cyc % 4 == 1) || (cyc % 4 == 2));
    endcase
    apply_drives();
  endtask

  function automatic bit all_idle();
    for (int r = 0; r < N; r++) if (src_q[r].size() > 0) return 1'b0;
    return (held.size() == 0) && (owner < 0);
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!all_idle()) begin
      step();
      n++;
      if (n > budget) begin
        total++;
        bad++;
        $display("FAIL drain_timeout at cycle %0d: got busy after %0d cycles expected idle", cyc, n);
        break;
      end
    end
    repeat (2) step();
  endtask

  task automatic wait_owner(input int r, input int budget);
    int n;
    n = 0;
    while (owner != r) begin
      step();
      n++;
      if (n > budget) begin
        total++;
        bad++;
        $display("FAIL grant_timeout at cycle %0d: got owner %0d expected %0d", cyc, owner, r);
        break;
      end
    end
  endtask

  task automatic clear_logs();
    dut_grants.delete();
    dut_beats.delete();
  endtask

  task automatic model_reset();
    held.delete();
    for (int r = 0; r < N; r++) begin
      src_q[r].delete();
      gap[r]  = 1'b0;
      mcnt[r] = '0;
    end
    owner  = -1;
    ptr    = 0;
    mgrant = 0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk156) begin
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      exp_rdy = '0;
      if (owner >= 0 && held.size() < 2) exp_rdy[owner] = 1'b1;
      chk("s_tready", 128'(bus.s_tready), 128'(exp_rdy));
      chk("m_tvalid", 128'(bus.m_tvalid), 128'(held.size() > 0));
      if (held.size() > 0) begin
        chk("m_tdata", 128'(bus.m_tdata), 128'(held[0].data));
        chk("m_tkeep", 128'(bus.m_tkeep), 128'(held[0].keep));
        chk("m_tlast", 128'(bus.m_tlast), 128'(held[0].last));
      end
      chk("grant_id", 128'(grant_id), 128'(mgrant));
      chk("busy", 128'(busy), 128'(owner >= 0));
      chk("pkt_cnt", 128'(pkt_cnt), 128'(exp_cnt()));
      if (busy && !busy_prev) dut_grants.push_back(int'(grant_id));
      if (bus.m_tvalid && bus.m_tready) dut_beats.push_back('{32'(cyc), bus.m_tdata, bus.m_tlast});
      if (pkt_cnt[63:32] != cnt1_prev) cnt1_log.push_back(pkt_cnt[63:32]);
    end
    busy_prev = busy;
    cnt1_prev = pkt_cnt[63:32];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    fid      = 0;
    gap_en   = 1'b0;
    rdy_mode = 0;
    mrdy     = 1'b1;
    chk_en   = 1'b0;
    model_reset();
    apply_drives();

    // Reset state
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_m_tvalid", 128'(bus.m_tvalid), 128'd0);
    chk("rst_m_tlast", 128'(bus.m_tlast), 128'd0);
    chk("rst_m_tdata", 128'(bus.m_tdata), 128'd0);
    chk("rst_m_tkeep", 128'(bus.m_tkeep), 128'd0);
    chk("rst_s_tready", 128'(bus.s_tready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_grant", 128'(grant_id), 128'd0);
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
    aresetn = 1'b1;
    chk_en  = 1'b1;
    repeat (2) step();

    // Scenario 1: all four sources, 4-beat frames, r0 has two
    clear_logs();
    add_frame(0, 4); add_frame(0, 4);
    add_frame(1, 4); add_frame(2, 4); add_frame(3, 4);
    run_until_idle(200);
    chk("s1_ngrants", 128'(dut_grants.size()), 128'd5);
    if (dut_grants.size() == 5) begin
      chk("s1_g0", 128'(dut_grants[0]), 128'd0);
      chk("s1_g1", 128'(dut_grants[1]), 128'd1);
      chk("s1_g2", 128'(dut_grants[2]), 128'd2);
      chk("s1_g3", 128'(dut_grants[3]), 128'd3);
      chk("s1_g4", 128'(dut_grants[4]), 128'd0);
    end
    chk("s1_nbeats", 128'(dut_beats.size()), 128'd20);
    if (dut_beats.size() == 20)
      for (int i = 1; i < 20; i++)
        chk("s1_spacing", 128'(dut_beats[i].cyc - dut_beats[i-1].cyc), (i % 4 == 0) ? 128'd2 : 128'd1);

    // Scenario 2: only r2, three single-beat frames
    clear_logs();
    add_single(2, 64'hA1); add_single(2, 64'hA2); add_single(2, 64'hA3);
    run_until_idle(100);
    chk("s2_ngrants", 128'(dut_grants.size()), 128'd3);
    for (int i = 0; i < dut_grants.size(); i++) chk("s2_grant", 128'(dut_grants[i]), 128'd2);
    chk("s2_nbeats", 128'(dut_beats.size()), 128'd3);
    if (dut_beats.size() == 3) begin
      chk("s2_d0", 128'(dut_beats[0].data), 128'hA1);
      chk("s2_d1", 128'(dut_beats[1].data), 128'hA2);
      chk("s2_d2", 128'(dut_beats[2].data), 128'hA3);
      chk("s2_last", 128'({dut_beats[0].last, dut_beats[1].last, dut_beats[2].last}), 128'b111);
      chk("s2_gap01", 128'(dut_beats[1].cyc - dut_beats[0].cyc), 128'd2);
      chk("s2_gap12", 128'(dut_beats[2].cyc - dut_beats[1].cyc), 128'd2);
    end

    // Scenario 3: r1 mid 8-beat frame, r0 requests, m_tready toggling
    clear_logs();
    rdy_mode = 2;
    add_frame(1, 8);
    wait_owner(1, 20);
    repeat (2) step();
    add_frame(0, 4);
    run_until_idle(200);
    rdy_mode = 0;
    chk("s3_ngrants", 128'(dut_grants.size()), 128'd2);
    if (dut_grants.size() == 2) begin
      chk("s3_g0", 128'(dut_grants[0]), 128'd1);
      chk("s3_g1", 128'(dut_grants[1]), 128'd0);
    end
    chk("s3_nbeats", 128'(dut_beats.size()), 128'd12);
    if (dut_beats.size() == 12)
      for (int i = 0; i < 12; i++) begin
        chk("s3_src", 128'(dut_beats[i].data[63:56]), (i < 8) ? 128'd1 : 128'd0);
        chk("s3_last", 128'(dut_beats[i].last), (i == 7 || i == 11) ? 128'd1 : 128'd0);
      end

    // Scenario 4: pointer at 3 after an r2 frame, r0 and r3 both request
    clear_logs();
    add_frame(2, 3);
    wait_owner(2, 20);
    add_frame(0, 2); add_frame(3, 2);
    run_until_idle(100);
    chk("s4_ngrants", 128'(dut_grants.size()), 128'd3);
    if (dut_grants.size() == 3) begin
      chk("s4_g0", 128'(dut_grants[0]), 128'd2);
      chk("s4_g1", 128'(dut_grants[1]), 128'd3);
      chk("s4_g2", 128'(dut_grants[2]), 128'd0);
    end

    // Scenario 5: reset at beat 3 of a 6-beat r0 frame (pointer was 1 before reset)
    add_frame(0, 6);
    begin
      int n;
      n = 0;
      while (src_q[0].size() > 3 && n < 30) begin step(); n++; end
    end
    chk("s5_accepted3", 128'(src_q[0].size()), 128'd3);
    #1;
    chk("s5_pre_mvalid", 128'(bus.m_tvalid), 128'd1);
    #1;
    chk_en  = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("s5_mvalid", 128'(bus.m_tvalid), 128'd0);
    chk("s5_busy", 128'(busy), 128'd0);
    chk("s5_grant", 128'(grant_id), 128'd0);
    chk("s5_sready", 128'(bus.s_tready), 128'd0);
    model_reset();
    apply_drives();
    repeat (2) @(posedge clk156);
    #1;
    aresetn = 1'b1;
    chk_en  = 1'b1;
    clear_logs();
    add_frame(0, 2); add_frame(3, 2);
    run_until_idle(100);
    chk("s5_ngrants", 128'(dut_grants.size()), 128'd2);
    if (dut_grants.size() == 2) begin
      chk("s5_g0", 128'(dut_grants[0]), 128'd0);
      chk("s5_g1", 128'(dut_grants[1]), 128'd3);
    end

    // Randomised traffic with random backpressure and inter-beat gaps
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2) == 0) begin
        int r;
        r = int'($urandom_range(N - 1));
        if (src_q[r].size() < 12) add_frame(r, int'($urandom_range(1, 6)));
      end
      step();
    end
    run_until_idle(2000);
    gap_en   = 1'b0;
    rdy_mode = 0;

`ifdef NET_TX_ARB_STATS_EN
    // Scenario 6: counter wrap on r1
    force dut.cnt_q = {mcnt[3], mcnt[2], 32'hFFFF_FFFE, mcnt[0]};
    mcnt[1]   = 32'hFFFF_FFFE;
    cnt1_prev = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    cnt1_log.delete();
    add_single(1, 64'hB1); add_single(1, 64'hB2); add_single(1, 64'hB3);
    run_until_idle(100);
    chk("s6_nlog", 128'(cnt1_log.size()), 128'd3);
    if (cnt1_log.size() == 3) begin
      chk("s6_c0", 128'(cnt1_log[0]), 128'hFFFF_FFFF);
      chk("s6_c1", 128'(cnt1_log[1]), 128'h0);
      chk("s6_c2", 128'(cnt1_log[2]), 128'h1);
    end
`else
    add_single(1, 64'hB1);
    run_until_idle(100);
    chk("s6_pkt_cnt_zero", 128'(pkt_cnt), 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
